riscv_mem_arbiter: RTL

Sits between riscv_core_sim and a single-port memory model. Arbitrates the core's separate instruction-fetch and data load/store request ports onto one memory command port, with fixed data-over-instruction priority and a starvation guard. Returns per-port acknowledge and read data, and rejects misaligned or illegal accesses without touching memory. Lets the core run against a unified single-port RAM instead of the dual-port riscv_memory.

---
 rtl/riscv_mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: merges the core's fetch and data request ports onto one
// single-port memory command port. One access in flight at a time, data has
// priority over fetch, and a starvation counter forces a pending fetch through
// after MAX_STARVE back-to-back data grants. Misaligned or reserved-size
// accesses are acknowledged with an error and never reach memory.
module riscv_mem_arbiter #(
  parameter int RD_LAT     = 1,  // 1..7
  parameter int MAX_STARVE = 4   // 1..15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [1:0]  m_size_o,
  output logic        m_rd_o,
  output logic        m_wr_o,
  input  logic [31:0] m_rdata_i
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic        own_i;       // current owner is the fetch port
  logic        op_wr;       // current access is a store
  logic [2:0]  wait_cnt;
  logic [3:0]  starve_cnt;

  logic        d_pend;
  logic        grant_i, grant_d, grant_err, grant_wr;
  logic        nxt_own_i, nxt_err;
  logic [31:0] nxt_rdata;

  assign d_pend = d_rd_i | d_wr_i;

  // Arbitration, legality check and next-state; also the response that the
  // output registers will present when entering RESP.
  always_comb begin
    state_d   = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_err = 1'b0;
    grant_wr  = 1'b0;
    nxt_own_i = own_i;
    nxt_err   = 1'b0;
    nxt_rdata = '0;
    case (state)
      IDLE: begin
        if (d_pend && !(i_req_i && starve_cnt == 4'(MAX_STARVE))) begin
          grant_d   = 1'b1;
          grant_wr  = d_wr_i;  // rd+wr together is a store
          grant_err = (d_size_i == 2'd3) ||
                      (d_size_i == 2'd1 && d_addr_i[0]) ||
                      (d_size_i == 2'd2 && d_addr_i[1:0] != 2'b00);
        end else if (i_req_i) begin
          grant_i   = 1'b1;
          grant_err = (i_addr_i[1:0] != 2'b00);
        end
        if (grant_i || grant_d) begin
          nxt_own_i = grant_i;
          nxt_err   = grant_err;
          state_d   = grant_err ? RESP : CMD;
        end
      end
      CMD:  state_d = op_wr ? RESP : WAIT;
      WAIT: begin
        if (wait_cnt == 3'(RD_LAT - 1)) begin
          state_d   = RESP;
          nxt_rdata = m_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus owner/op latch, read-latency and starvation counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      own_i      <= 1'b0;
      op_wr      <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state    <= state_d;
      own_i    <= nxt_own_i;
      if (grant_i || grant_d) op_wr <= grant_wr;
      wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && i_req_i && starve_cnt != 4'(MAX_STARVE))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Registered memory command and port responses; m_* fields only change
  // when a real command is issued so they hold between strobes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_size_o  <= '0;
      m_rd_o    <= 1'b0;
      m_wr_o    <= 1'b0;
      i_ack_o   <= 1'b0;
      i_err_o   <= 1'b0;
      i_rdata_o <= '0;
      d_ack_o   <= 1'b0;
      d_err_o   <= 1'b0;
      d_rdata_o <= '0;
    end else begin
      m_rd_o <= 1'b0;
      m_wr_o <= 1'b0;
      if (state_d == CMD) begin
        m_rd_o   <= !grant_wr;
        m_wr_o   <= grant_wr;
        m_addr_o <= grant_i ? i_addr_i : d_addr_i;
        m_size_o <= grant_i ? 2'd2 : d_size_i;
        if (grant_d) m_wdata_o <= d_wdata_i;
      end
      i_ack_o   <= (state_d == RESP) && nxt_own_i;
      i_err_o   <= (state_d == RESP) && nxt_own_i && nxt_err;
      i_rdata_o <= ((state_d == RESP) && nxt_own_i) ? nxt_rdata : '0;
      d_ack_o   <= (state_d == RESP) && !nxt_own_i;
      d_err_o   <= (state_d == RESP) && !nxt_own_i && nxt_err;
      d_rdata_o <= ((state_d == RESP) && !nxt_own_i) ? nxt_rdata : '0;
    end
  end

endmodule
